// File: rtl/alu_seq_rot_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared types for the sequential NOT/rotate ALU: opcode and FSM state
// encodings plus the opcode field width. Imported by the interface, the
// rotate-step helper and the top level.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int OP_W = 2;

  // Opcode encoding as seen on the operand bus.
  typedef enum logic [OP_W-1:0] {
    OP_NOT  = 2'b00,
    OP_ROL  = 2'b01,
    OP_ROR  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  // Control FSM: accept, serial rotate, hold result until consumed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : alu_seq_pkg

// File: rtl/alu_seq_rot_if.sv
// -----------------------------------------------------------------------------
// alu_seq_rot_if
// Operand/result bus of the sequential ALU.
//   Operand side : in_valid, in_ready, a[WIDTH], b[SW] (rotate amount), op[2]
//   Result side  : out_valid, out_ready, result[WIDTH], cf, sf, zf
// Modports:
//   slave  - the ALU (consumes operands, produces results)
//   master - the producer/consumer pair around it (register file, writeback)
// -----------------------------------------------------------------------------
interface alu_seq_rot_if
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int SW    = $clog2(WIDTH)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [SW-1:0]    b;
  logic [OP_W-1:0]  op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cf;
  logic             sf;
  logic             zf;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, cf, sf, zf
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, cf, sf, zf
  );

endinterface : alu_seq_rot_if

// File: rtl/alu_rot_step.sv
// -----------------------------------------------------------------------------
// alu_rot_step
// Combinational single-bit rotate of a WIDTH-bit vector.
//   din   in  WIDTH : vector to rotate
//   left  in  1     : 1 = rotate left, 0 = rotate right
//   dout  out WIDTH : rotated vector
//   wrap  out 1     : bit that wrapped around (din MSB for left, LSB for right)
// -----------------------------------------------------------------------------
module alu_rot_step #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] din,
  input  logic             left,
  output logic [WIDTH-1:0] dout,
  output logic             wrap
);

  always_comb begin
    if (left) begin
      dout = {din[WIDTH-2:0], din[WIDTH-1]};
      wrap = din[WIDTH-1];
    end else begin
      dout = {din[0], din[WIDTH-1:1]};
      wrap = din[0];
    end
  end

endmodule : alu_rot_step

// File: rtl/alu_seq_rot.sv
// -----------------------------------------------------------------------------
// alu_seq_rot
// Sequential ALU: NOT, rotate-left, rotate-right and pass on a WIDTH-bit
// operand. Rotates are performed serially, one bit position per cycle, so a
// rotate by k occupies the block for k cycles. Results and CF/SF/ZF flags are
// registered and held until the consumer takes them.
//   clk    in  : rising-edge clock
//   rst_n  in  : asynchronous active-low reset
//   bus    slave modport of alu_seq_rot_if:
//          in_valid/in_ready/a/b/op  - operand handshake (accepted in IDLE only)
//          out_valid/out_ready       - result handshake (held in DONE)
//          result/cf/sf/zf           - registered result and flags
// -----------------------------------------------------------------------------
module alu_seq_rot
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_rot_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [SW-1:0]    cnt_q,   cnt_d;
  logic             dir_q,   dir_d;   // 1 = rotate left
  logic             cf_q,    cf_d;
  logic             sf_q,    sf_d;
  logic             zf_q,    zf_d;

  logic [SW-1:0]    k;
  logic [WIDTH-1:0] step_out;
  logic             step_wrap;

  // Rotate amount reduced modulo WIDTH. b is SW bits wide, so b < 2*WIDTH and
  // a single conditional subtract is enough. For power-of-two widths the
  // compare is never true and k is just b.
  always_comb begin
    if ({1'b0, bus.b} >= (SW+1)'(WIDTH)) begin
      k = bus.b - SW'(WIDTH);
    end else begin
      k = bus.b;
    end
  end

  alu_rot_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .din  (acc_q),
    .left (dir_q),
    .dout (step_out),
    .wrap (step_wrap)
  );

  always_comb begin
    // NOTE: every variable gets a hold value first so no path through the
    // case statement leaves one unassigned (which would infer a latch).
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    cf_d    = cf_q;
    sf_d    = sf_q;
    zf_d    = zf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          cf_d = 1'b0;
          unique case (op_e'(bus.op))
            OP_NOT: begin
              acc_d   = ~bus.a;
              state_d = ST_DONE;
            end
            OP_PASS: begin
              acc_d   = bus.a;
              state_d = ST_DONE;
            end
            OP_ROL, OP_ROR: begin
              acc_d = bus.a;
              dir_d = (op_e'(bus.op) == OP_ROL);
              if (k == '0) begin
                state_d = ST_DONE;
              end else begin
                cnt_d   = k;
                state_d = ST_ROT;
              end
            end
          endcase
        end
      end

      ST_ROT: begin
        acc_d = step_out;
        cf_d  = step_wrap;
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Sign/zero are taken from the final accumulator value on the cycle the
    // FSM enters DONE, so they stay frozen while the result is held.
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      sf_d = acc_d[WIDTH-1];
      zf_d = (acc_d == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their _d values from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      cf_q    <= 1'b0;
      sf_q    <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      cf_q    <= cf_d;
      sf_q    <= sf_d;
      zf_q    <= zf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = acc_q;
  assign bus.cf        = cf_q;
  assign bus.sf        = sf_q;
  assign bus.zf        = zf_q;

endmodule : alu_seq_rot

// File: tb/tb_alu_seq_rot.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_rot
// Directed bench for alu_seq_rot at WIDTH=5. Each scenario task drives its own
// vectors and compares against hand-computed results, flags and latency
// (cycles from the accept edge to the first cycle out_valid is seen).
// -----------------------------------------------------------------------------
module tb_alu_seq_rot;
  import alu_seq_pkg::*;

  localparam int WIDTH = 5;
  localparam int SW    = $clog2(WIDTH);

  logic clk;
  logic rst_n;

  int tests_run = 0;
  int fails     = 0;

  typedef struct {
    string            name;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [SW-1:0]    b;
    int               lat;
    logic [WIDTH-1:0] res;
    logic             cf;
    logic             sf;
    logic             zf;
  } vec_t;

  alu_seq_rot_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_rot #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one operand, wait for the result and return what was observed.
  // lat = -1 means the op was never accepted or never completed in budget.
  task automatic issue_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [SW-1:0] b, output int lat,
                          output logic [WIDTH-1:0] res, output logic cf,
                          output logic sf, output logic zf);
    int waited = 0;
    lat = -1;
    res = 'x;
    cf  = 1'bx;
    sf  = 1'bx;
    zf  = 1'bx;
    @(negedge clk);
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) return;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    res = bus.result;
    cf  = bus.cf;
    sf  = bus.sf;
    zf  = bus.zf;
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    #12;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 5'b00000 ||
        bus.cf !== 1'b0 || bus.sf !== 1'b0 || bus.zf !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b result=%b cf=%b sf=%b zf=%b, expected 0 1 00000 0 0 0",
               bus.out_valid, bus.in_ready, bus.result, bus.cf, bus.sf, bus.zf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL after_reset_idle: out_valid=%b in_ready=%b, expected 0 1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_not_pass();
    vec_t v[4];
    int lat;
    logic [WIDTH-1:0] res;
    logic cf, sf, zf;
    v[0] = '{"not_10110",  OP_NOT,  5'b10110, 3'd0, 1, 5'b01001, 1'b0, 1'b0, 1'b0};
    v[1] = '{"not_11111",  OP_NOT,  5'b11111, 3'd2, 1, 5'b00000, 1'b0, 1'b0, 1'b1};
    v[2] = '{"pass_00000", OP_PASS, 5'b00000, 3'd3, 1, 5'b00000, 1'b0, 1'b0, 1'b1};
    v[3] = '{"pass_10101", OP_PASS, 5'b10101, 3'd7, 1, 5'b10101, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue_op(v[i].op, v[i].a, v[i].b, lat, res, cf, sf, zf);
      tests_run++;
      if (lat !== v[i].lat || res !== v[i].res || cf !== v[i].cf ||
          sf !== v[i].sf || zf !== v[i].zf) begin
        fails++;
        $display("FAIL %s: lat=%0d res=%b cf=%b sf=%b zf=%b, expected lat=%0d res=%b cf=%b sf=%b zf=%b",
                 v[i].name, lat, res, cf, sf, zf, v[i].lat, v[i].res, v[i].cf, v[i].sf, v[i].zf);
      end
      release_result();
    end
  endtask

  task automatic test_rotate();
    vec_t v[4];
    int lat;
    logic [WIDTH-1:0] res;
    logic cf, sf, zf;
    v[0] = '{"rol_10011_b1", OP_ROL, 5'b10011, 3'd1, 2, 5'b00111, 1'b1, 1'b0, 1'b0};
    v[1] = '{"rol_10011_b3", OP_ROL, 5'b10011, 3'd3, 4, 5'b11100, 1'b0, 1'b1, 1'b0};
    v[2] = '{"ror_00001_b6", OP_ROR, 5'b00001, 3'd6, 2, 5'b10000, 1'b1, 1'b1, 1'b0};
    v[3] = '{"ror_00001_b5", OP_ROR, 5'b00001, 3'd5, 1, 5'b00001, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue_op(v[i].op, v[i].a, v[i].b, lat, res, cf, sf, zf);
      tests_run++;
      if (lat !== v[i].lat || res !== v[i].res || cf !== v[i].cf ||
          sf !== v[i].sf || zf !== v[i].zf) begin
        fails++;
        $display("FAIL %s: lat=%0d res=%b cf=%b sf=%b zf=%b, expected lat=%0d res=%b cf=%b sf=%b zf=%b",
                 v[i].name, lat, res, cf, sf, zf, v[i].lat, v[i].res, v[i].cf, v[i].sf, v[i].zf);
      end
      release_result();
    end
  endtask

  task automatic test_boundary();
    vec_t v[5];
    int lat;
    logic [WIDTH-1:0] res;
    logic cf, sf, zf;
    v[0] = '{"rol_10011_b4_worst", OP_ROL, 5'b10011, 3'd4, 5, 5'b11001, 1'b1, 1'b1, 1'b0};
    v[1] = '{"ror_10110_b7",       OP_ROR, 5'b10110, 3'd7, 3, 5'b10101, 1'b1, 1'b1, 1'b0};
    v[2] = '{"rol_01000_b0",       OP_ROL, 5'b01000, 3'd0, 1, 5'b01000, 1'b0, 1'b0, 1'b0};
    v[3] = '{"ror_10000_b4",       OP_ROR, 5'b10000, 3'd4, 5, 5'b00001, 1'b0, 1'b0, 1'b0};
    v[4] = '{"rol_11111_b5",       OP_ROL, 5'b11111, 3'd5, 1, 5'b11111, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      issue_op(v[i].op, v[i].a, v[i].b, lat, res, cf, sf, zf);
      tests_run++;
      if (lat !== v[i].lat || res !== v[i].res || cf !== v[i].cf ||
          sf !== v[i].sf || zf !== v[i].zf) begin
        fails++;
        $display("FAIL %s: lat=%0d res=%b cf=%b sf=%b zf=%b, expected lat=%0d res=%b cf=%b sf=%b zf=%b",
                 v[i].name, lat, res, cf, sf, zf, v[i].lat, v[i].res, v[i].cf, v[i].sf, v[i].zf);
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [WIDTH-1:0] res;
    logic cf, sf, zf;
    issue_op(OP_ROL, 5'b10011, 3'd1, lat, res, cf, sf, zf);
    tests_run++;
    if (lat !== 2 || res !== 5'b00111 || cf !== 1'b1 || sf !== 1'b0 || zf !== 1'b0) begin
      fails++;
      $display("FAIL bp_first_op: lat=%0d res=%b cf=%b sf=%b zf=%b, expected lat=2 res=00111 cf=1 sf=0 zf=0",
               lat, res, cf, sf, zf);
    end
    // Hold the result for three cycles while the producer wiggles its inputs.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = ~bus.in_valid;
      bus.a        = 5'b01010 ^ 5'(i);
      bus.b        = 3'(i + 1);
      bus.op       = OP_NOT;
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 5'b00111 ||
          bus.cf !== 1'b1 || bus.sf !== 1'b0 || bus.zf !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b result=%b cf=%b sf=%b zf=%b, expected 1 0 00111 1 0 0",
                 i, bus.out_valid, bus.in_ready, bus.result, bus.cf, bus.sf, bus.zf);
      end
    end
    bus.in_valid = 1'b0;
    release_result();
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_back_to_idle: in_ready=%b out_valid=%b, expected 1 0",
               bus.in_ready, bus.out_valid);
    end
    issue_op(OP_PASS, 5'b01100, 3'd0, lat, res, cf, sf, zf);
    tests_run++;
    if (lat !== 1 || res !== 5'b01100 || cf !== 1'b0 || sf !== 1'b0 || zf !== 1'b0) begin
      fails++;
      $display("FAIL bp_next_op: lat=%0d res=%b cf=%b sf=%b zf=%b, expected lat=1 res=01100 cf=0 sf=0 zf=0",
               lat, res, cf, sf, zf);
    end
    release_result();
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen_valid;
    logic [WIDTH-1:0] res;
    logic cf, sf, zf;
    @(negedge clk);
    bus.op       = OP_ROL;
    bus.a        = 5'b10011;
    bus.b        = 3'd4;
    bus.in_valid = 1'b1;
    @(posedge clk);                 // accept edge T
    #1 bus.in_valid = 1'b0;
    @(posedge clk);                 // T+1
    @(posedge clk);                 // T+2
    #2;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL abort_mid_rot: out_valid=%b in_ready=%b, expected 0 0",
               bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.result !== 5'b00000 || bus.in_ready !== 1'b1 ||
        bus.cf !== 1'b0 || bus.sf !== 1'b0 || bus.zf !== 1'b0) begin
      fails++;
      $display("FAIL abort_reset_state: out_valid=%b result=%b in_ready=%b cf=%b sf=%b zf=%b, expected 0 00000 1 0 0 0",
               bus.out_valid, bus.result, bus.in_ready, bus.cf, bus.sf, bus.zf);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid++;
    end
    tests_run++;
    if (seen_valid !== 0) begin
      fails++;
      $display("FAIL abort_no_pulse: out_valid seen %0d cycles, expected 0", seen_valid);
    end
    issue_op(OP_PASS, 5'b01010, 3'd0, lat, res, cf, sf, zf);
    tests_run++;
    if (lat !== 1 || res !== 5'b01010 || cf !== 1'b0 || sf !== 1'b0 || zf !== 1'b0) begin
      fails++;
      $display("FAIL abort_then_pass: lat=%0d res=%b cf=%b sf=%b zf=%b, expected lat=1 res=01010 cf=0 sf=0 zf=0",
               lat, res, cf, sf, zf);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_not_pass();
    test_rotate();
    test_boundary();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule : tb_alu_seq_rot
